// File: rtl/sqrt_pack.sv
// sqrt_pack: output stage of the binary16 square-root datapath.
// Packs each finished iteration result into an IEEE-754 binary16 word and
// queues it in a first-word fall-through FIFO toward the consumer.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   enable              capture enable (FIFO drain continues when low)
//   it_valid, result    iteration-stage valid and result strobe
//   sign_in, exp_in     result sign and signed unbiased exponent
//   mant_in             11-bit mantissa, bit 10 is the hidden bit
//   is_nan_in, is_pinf_in, is_ninf_in   special-value flags
//   out_valid/out_ready/out_data        consumer handshake, head word
//   count               FIFO occupancy
//   overflow            sticky: a capture was dropped on a full FIFO
module sqrt_pack #(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              it_valid,
  input  logic              result,
  input  logic              sign_in,
  input  logic signed [6:0] exp_in,
  input  logic [10:0]       mant_in,
  input  logic              is_nan_in,
  input  logic              is_pinf_in,
  input  logic              is_ninf_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic [CW-1:0]     count,
  output logic              overflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          w_capture;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [4:0]    w_exp_biased;
  logic [15:0]   w_packed;

  assign w_capture = enable & it_valid & result;
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_pop     = out_valid & out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push    = w_capture & (~w_full | w_pop);

  // Only exponents -14..15 reach the biased path, so 5-bit wrap is exact.
  assign w_exp_biased = exp_in[4:0] + 5'd15;

  // binary16 packing, first matching rule wins
  always_comb begin
    w_packed = {sign_in, w_exp_biased, mant_in[9:0]};
    if (is_nan_in | is_ninf_in) begin
      w_packed = 16'h7E00;
    end else if (is_pinf_in) begin
      w_packed = 16'h7C00;
    end else if ((exp_in == -7'sd15) && (mant_in == 11'd0)) begin
      w_packed = {sign_in, 15'h0000};
    end else if (exp_in >= 7'sd16) begin
      w_packed = {sign_in, 15'h7C00};
    end else if (exp_in <= -7'sd15) begin
      w_packed = {sign_in, 15'h0000};
    end
  end

  // FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= 16'h0000;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_packed;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
      if (w_capture && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : 16'h0000;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_sqrt_pack.sv
// Directed bench for sqrt_pack with DEPTH = 2.
module tb_sqrt_pack;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        it_valid;
  logic        result;
  logic        sign_in;
  logic [6:0]  exp_in;
  logic [10:0] mant_in;
  logic        is_nan_in;
  logic        is_pinf_in;
  logic        is_ninf_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  count;
  logic        overflow;

  int n_pass;
  int n_total;

  sqrt_pack #(.DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .it_valid   (it_valid),
    .result     (result),
    .sign_in    (sign_in),
    .exp_in     (exp_in),
    .mant_in    (mant_in),
    .is_nan_in  (is_nan_in),
    .is_pinf_in (is_pinf_in),
    .is_ninf_in (is_ninf_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [6:0]  e;
    logic [10:0] m;
    logic        nan;
    logic        pinf;
    logic        ninf;
    logic [15:0] want;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic s, input logic [6:0] e, input logic [10:0] m,
                     input logic nan, input logic pinf, input logic ninf);
    enable     = 1'b1;
    it_valid   = 1'b1;
    result     = 1'b1;
    sign_in    = s;
    exp_in     = e;
    mant_in    = m;
    is_nan_in  = nan;
    is_pinf_in = pinf;
    is_ninf_in = ninf;
  endtask

  task automatic nocap();
    it_valid   = 1'b0;
    result     = 1'b0;
    is_nan_in  = 1'b0;
    is_pinf_in = 1'b0;
    is_ninf_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_q [10];
    int sent, recv, mcount;
    logic rdy, c, p;

    n_pass = 0;
    n_total = 0;

    //          s     exp        mant     nan   pinf  ninf  expected
    vecs[0]  = '{1'b0, 7'd0,      11'h5A8, 1'b0, 1'b0, 1'b0, 16'h3DA8};
    vecs[1]  = '{1'b1, 7'd3,      11'h400, 1'b1, 1'b0, 1'b0, 16'h7E00};
    vecs[2]  = '{1'b0, 7'd0,      11'h400, 1'b0, 1'b1, 1'b0, 16'h7C00};
    vecs[3]  = '{1'b1, 7'd0,      11'h400, 1'b0, 1'b0, 1'b1, 16'h7E00};
    vecs[4]  = '{1'b1, 7'(-15),   11'h000, 1'b0, 1'b0, 1'b0, 16'h8000};
    vecs[5]  = '{1'b1, 7'd16,     11'h400, 1'b0, 1'b0, 1'b0, 16'hFC00};
    vecs[6]  = '{1'b1, 7'(-15),   11'h400, 1'b0, 1'b0, 1'b0, 16'h8000};
    vecs[7]  = '{1'b0, 7'd15,     11'h7FF, 1'b0, 1'b0, 1'b0, 16'h7BFF};
    vecs[8]  = '{1'b1, 7'(-14),   11'h400, 1'b0, 1'b0, 1'b0, 16'h8400};
    vecs[9]  = '{1'b1, 7'd0,      11'h400, 1'b1, 1'b1, 1'b0, 16'h7E00};
    vecs[10] = '{1'b1, 7'(-15),   11'h000, 1'b0, 1'b1, 1'b0, 16'h7C00};
    vecs[11] = '{1'b0, 7'd63,     11'h400, 1'b0, 1'b0, 1'b0, 16'h7C00};
    vecs[12] = '{1'b1, 7'(-64),   11'h001, 1'b0, 1'b0, 1'b0, 16'h8000};
    vecs[13] = '{1'b0, 7'd1,      11'h400, 1'b0, 1'b0, 1'b0, 16'h4000};

    rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
    sign_in = 1'b0; exp_in = 7'd0; mant_in = 11'd0;
    nocap();
    tick();
    tick();
    rst = 1'b0;

    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data",  32'(out_data),  32'h0);
    chk("reset count",     32'(count),     32'd0);
    chk("reset overflow",  32'(overflow),  32'd0);

    // Packing table: one capture, check head, then pop it.
    for (int i = 0; i < NV; i++) begin
      cap(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].nan, vecs[i].pinf, vecs[i].ninf);
      out_ready = 1'b0;
      tick();
      nocap();
      chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].want));
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d count", i), 32'(count), 32'd1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("vec%0d drained count", i), 32'(count), 32'd0);
      chk($sformatf("vec%0d drained valid", i), 32'(out_valid), 32'd0);
      chk($sformatf("vec%0d drained data", i), 32'(out_data), 32'h0);
    end

    // Specials back-to-back with out_ready held high.
    out_ready = 1'b1;
    cap(1'b0, 7'd0, 11'h400, 1'b1, 1'b0, 1'b0); tick();
    chk("spec nan", 32'(out_data), 32'h7E00);
    cap(1'b0, 7'd0, 11'h400, 1'b0, 1'b1, 1'b0); tick();
    chk("spec pinf", 32'(out_data), 32'h7C00);
    chk("spec count steady", 32'(count), 32'd1);
    cap(1'b1, 7'd0, 11'h400, 1'b0, 1'b0, 1'b1); tick();
    chk("spec ninf", 32'(out_data), 32'h7E00);
    cap(1'b1, 7'(-15), 11'h000, 1'b0, 1'b0, 1'b0); tick();
    chk("spec -zero", 32'(out_data), 32'h8000);
    chk("spec valid", 32'(out_valid), 32'd1);
    nocap(); tick();
    chk("spec drained", 32'(count), 32'd0);
    out_ready = 1'b0;

    // enable low blocks capture; result low blocks capture.
    cap(1'b0, 7'd1, 11'h400, 1'b0, 1'b0, 1'b0);
    enable = 1'b0; tick();
    chk("enable0 count", 32'(count), 32'd0);
    enable = 1'b1; result = 1'b0; tick();
    chk("result0 count", 32'(count), 32'd0);
    nocap();

    // Back-pressure and overflow.
    cap(1'b0, 7'd1, 11'h400, 1'b0, 1'b0, 1'b0); tick();
    cap(1'b0, 7'd2, 11'h400, 1'b0, 1'b0, 1'b0); tick();
    chk("bp count2", 32'(count), 32'd2);
    chk("bp no ovf yet", 32'(overflow), 32'd0);
    cap(1'b0, 7'd3, 11'h400, 1'b0, 1'b0, 1'b0); tick();
    nocap();
    chk("bp count full", 32'(count), 32'd2);
    chk("bp overflow", 32'(overflow), 32'd1);
    chk("bp head stable", 32'(out_data), 32'h4000);
    tick();
    chk("bp head hold", 32'(out_data), 32'h4000);
    out_ready = 1'b1; tick();
    chk("bp drain2", 32'(out_data), 32'h4400);
    chk("bp drain2 count", 32'(count), 32'd1);
    tick();
    out_ready = 1'b0;
    chk("bp empty valid", 32'(out_valid), 32'd0);
    chk("bp ovf sticky", 32'(overflow), 32'd1);

    // Reset with two entries queued and a capture in flight.
    cap(1'b0, 7'd1, 11'h400, 1'b0, 1'b0, 1'b0); tick();
    cap(1'b0, 7'd2, 11'h400, 1'b0, 1'b0, 1'b0); tick();
    chk("pre-rst count", 32'(count), 32'd2);
    cap(1'b0, 7'd3, 11'h400, 1'b0, 1'b0, 1'b0);
    do_reset();
    nocap();
    chk("rst count", 32'(count), 32'd0);
    chk("rst valid", 32'(out_valid), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    chk("rst data", 32'(out_data), 32'h0);

    // Full FIFO with simultaneous push and pop.
    cap(1'b0, 7'd1, 11'h400, 1'b0, 1'b0, 1'b0); tick();
    cap(1'b0, 7'd2, 11'h400, 1'b0, 1'b0, 1'b0); tick();
    cap(1'b0, 7'd3, 11'h400, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1; tick();
    nocap();
    chk("full pp count", 32'(count), 32'd2);
    chk("full pp no ovf", 32'(overflow), 32'd0);
    chk("full pp head", 32'(out_data), 32'h4400);
    tick();
    chk("full pp third", 32'(out_data), 32'h4800);
    tick();
    chk("full pp empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Pointer wrap: 10 words, alternating out_ready, bench-side occupancy model.
    for (int i = 0; i < 10; i++) exp_q[i] = {1'b0, 5'(i + 15), 10'(i)};
    sent = 0; recv = 0; mcount = 0;
    for (int cyc = 0; cyc < 100 && recv < 10; cyc++) begin
      rdy = cyc[0];
      p = rdy && (mcount > 0);
      c = (sent < 10) && (mcount < 2 || p);
      chk("wrap valid", 32'(out_valid), 32'(mcount > 0));
      if (p) begin
        chk($sformatf("wrap word%0d", recv), 32'(out_data), 32'(exp_q[recv]));
        recv++;
      end
      out_ready = rdy;
      if (c) begin
        cap(1'b0, 7'(sent), 11'h400 | 11'(sent), 1'b0, 1'b0, 1'b0);
        sent++;
      end else begin
        nocap();
      end
      tick();
      mcount = mcount + (c ? 1 : 0) - (p ? 1 : 0);
    end
    nocap();
    out_ready = 1'b0;
    chk("wrap received all", 32'(recv), 32'd10);
    chk("wrap final count", 32'(count), 32'd0);
    chk("wrap no ovf", 32'(overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
